// File: rtl/alu_md_controller_if.sv
// rtl/alu_md_controller_if.sv - decode/handshake bus between execute stage and the ALU M-op controller
interface alu_md_controller_if #(
    parameter int XLEN = 32
);
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic            is_rtype;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      Operation;
    logic            is_md;
    logic            stall;
    logic [XLEN-1:0] md_result;
    logic            out_valid;
    logic            out_ready;
    logic            flush;

    // pipeline / controller side
    modport master (
        output ALUOp, Funct7, Funct3, is_rtype, src_a, src_b, in_valid, out_ready, flush,
        input  in_ready, Operation, is_md, stall, md_result, out_valid
    );

    // ALU controller side
    modport slave (
        input  ALUOp, Funct7, Funct3, is_rtype, src_a, src_b, in_valid, out_ready, flush,
        output in_ready, Operation, is_md, stall, md_result, out_valid
    );
endinterface

// File: rtl/alu_md_controller.sv
// rtl/alu_md_controller.sv - ALU op decoder plus iterative RV M-extension mul/div sequencer (optional ALU_MD_EARLY_OUT_EN)
module alu_md_controller #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    alu_md_controller_if.slave bus
);
    localparam int PW = 2 * XLEN;

    localparam logic [3:0] OP_AND    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_OR     = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SLT    = 4'b0101;
    localparam logic [3:0] OP_SRL    = 4'b0110;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_BRANCH = 4'b1000;
    localparam logic [3:0] OP_XOR    = 4'b1001;
    localparam logic [3:0] OP_SLTU   = 4'b1010;
    localparam logic [3:0] OP_PASS_B = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d;       // MUL: product accumulator; DIV: {remainder, dividend/quotient}
    logic [PW-1:0]   mcand_q, mcand_d;   // MUL: shifted multiplicand; DIV: divisor in low half
    logic [XLEN-1:0] mplier_q, mplier_d; // MUL: remaining multiplier bits
    logic [1:0]      f3_q, f3_d;         // low Funct3 bits select the result half / quotient vs remainder
    logic            qneg_q, qneg_d;     // product or quotient must be negated
    logic            rneg_q, rneg_d;     // remainder must be negated
    logic [XLEN-1:0] md_result_q, md_result_d;

    logic [3:0]      op_c;
    logic            is_md_c;
    logic            accept;
    logic            signed_a, signed_b, sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;
    logic [PW-1:0]   addend;
    logic [XLEN:0]   rem_sh, diff;
    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    // single-cycle ALU operation decode and M-op detection
    always_comb begin
        is_md_c = (bus.ALUOp == 2'b10) && bus.is_rtype && (bus.Funct7 == 7'b0000001);
        op_c    = OP_ADD;
        case (bus.ALUOp)
            2'b00: op_c = OP_ADD;
            2'b01: op_c = OP_BRANCH;
            2'b11: op_c = OP_PASS_B;
            default: begin
                case (bus.Funct3)
                    3'b000: op_c = (bus.is_rtype && bus.Funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
                    3'b001: op_c = OP_SLL;
                    3'b010: op_c = OP_SLT;
                    3'b011: op_c = OP_SLTU;
                    3'b100: op_c = OP_XOR;
                    3'b101: op_c = (bus.Funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
                    3'b110: op_c = OP_OR;
                    default: op_c = OP_AND;
                endcase
                if (is_md_c) op_c = OP_ADD;
            end
        endcase
    end

    // operand signedness, magnitudes and the divide fast-path conditions
    always_comb begin
        accept   = (state_q == S_IDLE) && bus.in_valid && is_md_c;
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (bus.Funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin signed_a = 1'b1; signed_b = 1'b1; end
            3'b010:                         signed_a = 1'b1;
            default:                        ;
        endcase
        sa       = signed_a & bus.src_a[XLEN-1];
        sb       = signed_b & bus.src_b[XLEN-1];
        a_mag    = sa ? -bus.src_a : bus.src_a;
        b_mag    = sb ? -bus.src_b : bus.src_b;
        div_zero = bus.Funct3[2] && (bus.src_b == '0);
        div_ovf  = (bus.Funct3 == 3'b100 || bus.Funct3 == 3'b110) &&
                   (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src_b == '1);
    end

    // one shift-add / restoring-divide step and the final sign fix-up
    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        rem_sh   = acc_q[PW-1:XLEN-1];
        diff     = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
        prod_fix = qneg_q ? -acc_q : acc_q;
        quo_fix  = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = rneg_q ? -acc_q[PW-1:XLEN] : acc_q[PW-1:XLEN];
    end

    // next state: accept, iterate until the counter drains, hold result until consumed
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = (div_zero || div_ovf) ? S_DONE :
                                          (bus.Funct3[2] ? S_DIV : S_MUL);
            S_MUL,
            S_DIV:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
        endcase
        if (bus.flush) state_d = S_IDLE;
    end

    // datapath: operand latch, per-cycle iteration, result capture
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        f3_d        = f3_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        md_result_d = md_result_q;
        case (state_q)
            S_IDLE: if (accept) begin
                f3_d   = bus.Funct3[1:0];
                qneg_d = sa ^ sb;
                rneg_d = sa;
                cnt_d  = CNT_W'(XLEN);
                if (bus.Funct3[2]) begin
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    mcand_d = {{XLEN{1'b0}}, b_mag};
                end else begin
                    acc_d    = '0;
                    mcand_d  = {{XLEN{1'b0}}, a_mag};
                    mplier_d = b_mag;
                end
                if (div_zero) begin
                    cnt_d       = '0;
                    md_result_d = bus.Funct3[1] ? bus.src_a : '1;
                end else if (div_ovf) begin
                    cnt_d       = '0;
                    md_result_d = bus.Funct3[1] ? '0 : bus.src_a;
                end
            end
            S_MUL: if (cnt_q != '0) begin
                acc_d    = acc_q + addend;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
`ifdef ALU_MD_EARLY_OUT_EN
                // no multiplier bits left after this step: product is already final
                if (mplier_q[XLEN-1:1] == '0) cnt_d = '0;
`endif
            end else begin
                md_result_d = (f3_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
            end
            S_DIV: if (cnt_q != '0) begin
                acc_d = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                md_result_d = f3_q[1] ? rem_fix : quo_fix;
            end
            default: ;
        endcase
        if (bus.flush) begin
            cnt_d       = '0;
            md_result_d = md_result_q;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            f3_q        <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            md_result_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            f3_q        <= f3_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            md_result_q <= md_result_d;
        end
    end

    // outputs: handshake, pipeline stall and decode results
    always_comb begin
        bus.Operation = op_c;
        bus.is_md     = is_md_c;
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.md_result = md_result_q;
        bus.stall     = (state_q == S_MUL) || (state_q == S_DIV) ||
                        ((state_q == S_IDLE) && bus.in_valid && is_md_c) ||
                        ((state_q == S_DONE) && !bus.out_ready);
    end
endmodule

// File: tb/tb_alu_md_controller.sv
// tb/tb_alu_md_controller.sv - self-checking bench for alu_md_controller (honours ALU_MD_EARLY_OUT_EN)
module tb_alu_md_controller;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_md_controller_if #(.XLEN(XLEN)) bus ();
    alu_md_controller #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [1:0] aluop;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       rt;
        logic [3:0] op;
        logic       md;
    } dec_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } md_vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
        logic        is_mul;
    } exp_t;

    exp_t     sb_q[$];
    dec_vec_t dec_tab[11];
    md_vec_t  md_tab[14];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic rdy);
        bus.ALUOp     = 2'b10;
        bus.Funct7    = 7'b0000001;
        bus.is_rtype  = 1'b1;
        bus.Funct3    = f3;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.out_ready = rdy;
        bus.in_valid  = 1'b1;
    endtask

    // from just after the accept edge, count edges until out_valid; stall must stay high meanwhile
    task automatic wait_valid(output int lat, inout logic stall_ok);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        exp_t e;
        exp_t got;
        int   lat;
        logic stall_ok;
        e.res = exp_res; e.lat = exp_lat; e.is_mul = ~f3[2];
        drive_md(f3, a, b, 1'b1);
        #1;
        stall_ok = (bus.stall === 1'b1) && (bus.in_ready === 1'b1);
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid(lat, stall_ok);
        got = sb_q.pop_front();
        if (lat >= 200) begin
            n_total++;
            $display("FAIL %s timeout: no out_valid within 200 cycles, expected result 0x%0h", name, got.res);
        end else begin
            check($sformatf("%s result", name), 64'(bus.md_result), 64'(got.res));
`ifdef ALU_MD_EARLY_OUT_EN
            if (got.is_mul) check($sformatf("%s latency<=%0d (lat=%0d)", name, got.lat, lat),
                                  64'(lat <= got.lat), 64'(1));
            else            check($sformatf("%s latency", name), 64'(lat), 64'(got.lat));
`else
            check($sformatf("%s latency", name), 64'(lat), 64'(got.lat));
`endif
            if (bus.stall !== 1'b0) stall_ok = 1'b0;
            check($sformatf("%s stall profile", name), 64'(stall_ok), 64'(1));
            @(posedge clk); #1;
            check($sformatf("%s consumed", name), 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
        end
    endtask

    initial begin
        int   lat;
        logic ok;
        logic stall_ok;

        dec_tab[0]  = '{2'b10, 7'b0100000, 3'b000, 1'b1, 4'b0001, 1'b0};
        dec_tab[1]  = '{2'b10, 7'b0100000, 3'b000, 1'b0, 4'b0010, 1'b0};
        dec_tab[2]  = '{2'b10, 7'b0100000, 3'b101, 1'b1, 4'b0111, 1'b0};
        dec_tab[3]  = '{2'b01, 7'b0000000, 3'b000, 1'b0, 4'b1000, 1'b0};
        dec_tab[4]  = '{2'b11, 7'b0000000, 3'b000, 1'b0, 4'b1011, 1'b0};
        dec_tab[5]  = '{2'b10, 7'b0000000, 3'b101, 1'b0, 4'b0110, 1'b0};
        dec_tab[6]  = '{2'b10, 7'b0000001, 3'b100, 1'b1, 4'b0010, 1'b1};
        dec_tab[7]  = '{2'b10, 7'b0000000, 3'b111, 1'b1, 4'b0000, 1'b0};
        dec_tab[8]  = '{2'b00, 7'b0100000, 3'b000, 1'b1, 4'b0010, 1'b0};
        dec_tab[9]  = '{2'b10, 7'b0000000, 3'b011, 1'b0, 4'b1010, 1'b0};
        dec_tab[10] = '{2'b10, 7'b0000001, 3'b100, 1'b0, 4'b1001, 1'b0};

        md_tab[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFF9, 33};
        md_tab[1]  = '{3'b011, 32'hFFFFFFFF, 32'h00000007, 32'h00000006, 33};
        md_tab[2]  = '{3'b001, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF, 33};
        md_tab[3]  = '{3'b010, 32'h00000002, 32'h80000000, 32'h00000001, 33};
        md_tab[4]  = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33};
        md_tab[5]  = '{3'b100, 32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFA, 33};
        md_tab[6]  = '{3'b110, 32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFE, 33};
        md_tab[7]  = '{3'b101, 32'h00000064, 32'h00000007, 32'h0000000E, 33};
        md_tab[8]  = '{3'b111, 32'h00000064, 32'h00000007, 32'h00000002, 33};
        md_tab[9]  = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        md_tab[10] = '{3'b101, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 0};
        md_tab[11] = '{3'b111, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 0};
        md_tab[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0};
        md_tab[13] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};

        reset         = 1'b1;
        bus.ALUOp     = 2'b00;
        bus.Funct7    = 7'b0;
        bus.Funct3    = 3'b0;
        bus.is_rtype  = 1'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset state {in_ready,stall,out_valid}",
              64'({bus.in_ready, bus.stall, bus.out_valid}), 64'(3'b100));
        check("reset md_result", 64'(bus.md_result), 64'(0));

        foreach (dec_tab[i]) begin
            bus.ALUOp    = dec_tab[i].aluop;
            bus.Funct7   = dec_tab[i].f7;
            bus.Funct3   = dec_tab[i].f3;
            bus.is_rtype = dec_tab[i].rt;
            #1;
            check($sformatf("decode[%0d] Operation", i), 64'(bus.Operation), 64'(dec_tab[i].op));
            check($sformatf("decode[%0d] is_md", i), 64'(bus.is_md), 64'(dec_tab[i].md));
        end
        @(posedge clk); #1;

        foreach (md_tab[i])
            run_mop($sformatf("mop[%0d] f3=%0d", i, md_tab[i].f3), md_tab[i].f3,
                    md_tab[i].a, md_tab[i].b, md_tab[i].res, md_tab[i].lat);

        // result held in DONE while the consumer is not ready
        drive_md(3'b101, 32'd100, 32'd7, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        stall_ok = 1'b1;
        wait_valid(lat, stall_ok);
        check("hold reaches DONE", 64'(bus.out_valid), 64'(1));
        ok = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.md_result !== 32'd14 || bus.stall !== 1'b1 || bus.out_valid !== 1'b1) ok = 1'b0;
        end
        check("hold 5 cycles stable/stalled", 64'(ok), 64'(1));
        bus.out_ready = 1'b1;
        #1;
        check("hold release stall", 64'(bus.stall), 64'(0));
        @(posedge clk); #1;
        check("hold release out_valid", 64'(bus.out_valid), 64'(0));

        // flush at iteration 10
        drive_md(3'b011, 32'd3, 32'hFFFFFFFF, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush {in_ready,stall,out_valid}",
              64'({bus.in_ready, bus.stall, bus.out_valid}), 64'(3'b100));
        check("flush md_result kept", 64'(bus.md_result), 64'(14));
        ok = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) ok = 1'b0;
        end
        check("flush out_valid never rises", 64'(ok), 64'(1));

        // flush wins over an accept in the same cycle
        drive_md(3'b100, 32'd50, 32'd5, 1'b1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        #1;
        check("flush beats accept", 64'({bus.in_ready, bus.stall}), 64'(2'b10));

        // asynchronous reset at iteration 10
        drive_md(3'b100, 32'd1000, 32'd7, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async reset {in_ready,stall,out_valid}",
              64'({bus.in_ready, bus.stall, bus.out_valid}), 64'(3'b100));
        check("async reset md_result", 64'(bus.md_result), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

`ifdef ALU_MD_EARLY_OUT_EN
        run_mop("early MUL 5*1", 3'b000, 32'd5, 32'd1, 32'd5, 2);
`else
        run_mop("MUL 5*1", 3'b000, 32'd5, 32'd1, 32'd5, 33);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/alu_md_controller.md
Name: alu_md_controller

Overview:
- Next-generation ALU controller with two jobs:
  - Combinationally decodes ALUOp/Funct3/Funct7 into a 4-bit ALU operation code for single-cycle ops.
  - Sequences RV32M/RV64M multiply/divide (Funct7=0000001) on an iterative shift-add/restoring datapath.
- Sits between the main Controller and the execute stage. Drives a stall to the pipeline while an M-op is in flight.
- XLEN is parametrised.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ALUOp  in  2  00 load/store/auipc; 01 branch; 10 R/I-type; 11 jal/lui.
- Funct7  in  7  instruction bits 31:25.
- Funct3  in  3  instruction bits 14:12.
- is_rtype  in  1  1 = R-type (qualifies Funct7 for SUB/M-ops; I-type ignores Funct7 except SRAI).
- src_a  in  XLEN  rs1 value.
- src_b  in  XLEN  rs2 value.
- in_valid  in  1  instruction valid in execute.
- in_ready  out  1  M-unit can accept (state IDLE).
- Operation  out  4  ALU op code (combinational).
- is_md  out  1  decoded op is an M-op (combinational).
- stall  out  1  hold the pipeline.
- md_result  out  XLEN  registered M-op result.
- out_valid  out  1  md_result valid.
- out_ready  in  1  consumer accepts md_result.
- flush  in  1  synchronous abort of the in-flight M-op.

Behaviour:
- Operation encoding (combinational):
  - 0000 AND; 0001 SUB; 0010 ADD; 0011 OR; 0100 SLL; 0101 SLT; 0110 SRL; 0111 SRA; 1000 BRANCH; 1001 XOR; 1010 SLTU; 1011 PASS_B.
  - ALUOp 00 -> ADD; 01 -> BRANCH; 11 -> PASS_B.
  - ALUOp 10, Funct3 000: SUB if is_rtype and Funct7=0100000, else ADD.
  - ALUOp 10, Funct3 101: SRA if Funct7=0100000, else SRL.
  - Undefined combos -> ADD.
  - is_md=1 -> Operation=ADD (don't-care to ALU).
- is_md = (ALUOp==10) & is_rtype & (Funct7==0000001).
- Accept: in_valid & is_md & in_ready at a rising edge latches operands, Funct3, and sign flags.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL for Funct3 0xx; IDLE -> DIV for Funct3 1xx; taken on accept.
  - MUL/DIV: one iteration per cycle for XLEN cycles (counter down to 0), then -> DONE.
  - DONE: out_valid=1, md_result stable until out_ready; out_valid & out_ready -> IDLE.
- Arithmetic:
  - Operands are converted to magnitudes per Funct3:
    - MUL, MULH, DIV, REM: both operands signed.
    - MULHSU: src_a signed only.
    - Unsigned variants: no conversion.
  - Product is 2*XLEN bits. Sign fix-up is applied on the DIV/MUL -> DONE transition.
  - Result selection: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits.
  - Remainder sign follows the dividend; quotient sign = sign_a ^ sign_b.
- Latency: accept at edge T -> out_valid asserted after edge T+XLEN+1 (33 cycles at XLEN=32).
- Divide by zero: DIV/IDLE skip iteration and go IDLE -> DONE in 1 cycle.
  - Quotient = all ones; remainder = src_a.
- Signed overflow (src_a = -2^(XLEN-1), src_b = -1, DIV/REM): 1-cycle fast path.
  - Quotient = src_a; remainder = 0.
- stall = (state==MUL|DIV) | (state==IDLE & in_valid & is_md) | (state==DONE & ~out_ready).
  - stall is low in the cycle the result is consumed.
- flush: any state -> IDLE next edge; out_valid=0; md_result unchanged. Flush has priority over accept and completion in the same cycle.
- Reset (asynchronous, any time, including mid-operation):
  - State IDLE; counter 0; md_result 0; out_valid 0.
  - in_ready=1; stall=0 (in_valid low).
- Non-M instructions never enter the FSM. While the FSM is busy, stall keeps them from advancing.

Optional Feature:
- Macro: ALU_MD_EARLY_OUT_EN.
- Defined: a multiply ends when the remaining multiplier magnitude bits are all zero. The product is shifted to final alignment in one step and the FSM goes -> DONE next cycle.
  - Minimum multiply latency: 2 cycles (multiplier 0 or 1).
  - Divide latency is unchanged.
- Undefined: all multiplies take exactly XLEN iterations; no early-out logic is synthesised.

Test Plan:
- Decode sweep: ALUOp=10, Funct3=000, Funct7=0100000, is_rtype=1 -> Operation=0001; same with is_rtype=0 -> 0010; Funct3=101, Funct7=0100000 -> 0111; ALUOp=01 -> 1000; ALUOp=11 -> 1011.
- MUL, XLEN=32: src_a=0xFFFFFFFF (-1), src_b=7, Funct3=000 -> md_result=0xFFFFFFF9 at T+33. MULHU with the same operands -> 0x00000006. stall high on cycles T..T+32.
- DIV: src_a=-20 (0xFFFFFFEC), src_b=3, Funct3=100 -> 0xFFFFFFFA. REM with the same operands -> 0xFFFFFFFE.
- Boundaries:
  - DIVU with src_b=0 -> 0xFFFFFFFF, out_valid next cycle.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
  - DIV with the same operands -> 0x80000000.
- Handshake/abort:
  - Hold out_ready=0 for 5 cycles in DONE -> md_result stable, stall=1.
  - Assert flush at iteration 10 -> IDLE next cycle, out_valid never rises.
  - Assert reset at iteration 10 -> all outputs at reset values immediately (asynchronous).
- With ALU_MD_EARLY_OUT_EN: MUL src_a=5, src_b=1 -> md_result=5 within 2 cycles. Without the macro: same result at T+33.
